// File: rtl/demux_pkg.sv
// Shared definitions for the demux32 serial capture block.
//   WIDTH   : captured word width (must equal 2**SEL_W)
//   SEL_W   : width of the bit pointer / addressed-mode select
//   state_e : capture FSM states (PAR is only reached when DEMUX32_PARITY_CHK_EN is defined)
package demux_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SEL_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAR  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_ptr_ctr.sv
// Wrap-around bit pointer with synchronous clear and count enable.
// Shared between the serializer-side mux select and the capture-side demux.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   clr_i  : synchronous clear to zero (wins over en_i)
//   en_i   : advance by one, wrapping 2**W-1 -> 0
//   cnt_o  : current pointer value
module bit_ptr_ctr #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux32_deser.sv
// Serial-to-parallel capture: collects an LSB-first serial word into a shadow register and
// commits it to a held output with a one-cycle frame_valid pulse. An addressed mode writes a
// single frame_out bit selected by sel (registered 1-to-32 demux).
// Optional build macro DEMUX32_PARITY_CHK_EN: an even-parity bit follows bit 31 and the
// commit happens on the parity bit; parity_err reports the check. Otherwise parity_err = 0.
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   din         : serial data bit
//   din_valid   : din valid this cycle
//   addr_mode   : 1 = addressed write at sel, 0 = auto-increment capture
//   sel         : bit index for addressed writes
//   clear       : drop the partial frame (shadow and pointer to zero)
//   frame_out   : last committed word (held)
//   frame_valid : one-cycle pulse after a completed frame commits
//   bit_ptr     : next shadow bit position
//   busy        : partial auto-mode frame held
//   parity_err  : parity result of the last committed frame
module demux32_deser #(
  parameter int unsigned WIDTH = demux_pkg::WIDTH,
  parameter int unsigned SEL_W = demux_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             addr_mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             clear,
  output logic [WIDTH-1:0] frame_out,
  output logic             frame_valid,
  output logic [SEL_W-1:0] bit_ptr,
  output logic             busy,
  output logic             parity_err
);

  import demux_pkg::*;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic             fv_q, fv_d;
  logic [SEL_W-1:0] ptr;
  logic             auto_wr, addr_wr, last_bit;

  // clear drops any same-cycle write, auto or addressed.
  assign auto_wr  = din_valid & ~addr_mode & ~clear;
  assign addr_wr  = din_valid &  addr_mode & ~clear;
  assign last_bit = (ptr == SEL_W'(WIDTH - 1));

  // Pointer holds at 0 while waiting for the parity bit.
  bit_ptr_ctr #(
    .W (SEL_W)
  ) u_ptr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (clear),
    .en_i   (auto_wr && (state_q != PAR)),
    .cnt_o  (ptr)
  );

`ifdef DEMUX32_PARITY_CHK_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
`ifdef DEMUX32_PARITY_CHK_EN
    perr_d   = perr_q;
`endif
    if (clear) begin
      shadow_d = '0;
      state_d  = IDLE;
    end else if (addr_wr) begin
      frame_d[sel] = din;
    end else if (auto_wr) begin
`ifdef DEMUX32_PARITY_CHK_EN
      if (state_q == PAR) begin
        // din is the even-parity bit: any odd total over data+parity is an error.
        frame_d  = shadow_q;
        perr_d   = ^{shadow_q, din};
        fv_d     = 1'b1;
        shadow_d = '0;
        state_d  = IDLE;
      end else begin
        shadow_d[ptr] = din;
        state_d       = last_bit ? PAR : FILL;
      end
`else
      if (last_bit) begin
        // Last bit bypasses the shadow and lands directly in the committed word.
        frame_d            = shadow_q;
        frame_d[WIDTH-1]   = din;
        fv_d               = 1'b1;
        shadow_d           = '0;
        state_d            = IDLE;
      end else begin
        shadow_d[ptr] = din;
        state_d       = FILL;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
`ifdef DEMUX32_PARITY_CHK_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
`ifdef DEMUX32_PARITY_CHK_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = fv_q;
  assign bit_ptr     = ptr;
  assign busy        = (state_q != IDLE);
`ifdef DEMUX32_PARITY_CHK_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_demux32_deser.sv
// Self-checking bench for demux32_deser: directed scenarios plus a randomized mix, all checked
// against a queue-based model of the serial capture behaviour.
module tb_demux32_deser;

`ifdef DEMUX32_PARITY_CHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_LEN = 32 + int'(PAR_EN);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        addr_mode = 1'b0;
  logic [4:0]  sel = '0;
  logic        clear = 1'b0;
  logic [31:0] frame_out;
  logic        frame_valid;
  logic [4:0]  bit_ptr;
  logic        busy;
  logic        parity_err;

  demux32_deser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .addr_mode   (addr_mode),
    .sel         (sel),
    .clear       (clear),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .bit_ptr     (bit_ptr),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_early = 0;

  // Model: bits collected so far in the current auto frame, plus the visible outputs.
  bit          q_bits[$];
  logic [31:0] m_frame = '0;
  logic        m_fv = 1'b0;
  logic        m_perr = 1'b0;

  function automatic logic [31:0] pack_bits();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = q_bits[i];
    return w;
  endfunction

  function automatic logic [4:0] m_ptr();
    return 5'(q_bits.size() % 32);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
  task automatic step(input logic v, input logic am, input logic [4:0] s, input logic d,
                      input logic clr, input logic rn);
    logic [31:0] w;
    din_valid = v; addr_mode = am; sel = s; din = d; clear = clr; rst_n = rn;
    @(posedge clk);
    m_fv = 1'b0;
    if (!rn) begin
      q_bits.delete(); m_frame = '0; m_perr = 1'b0;
    end else if (clr) begin
      q_bits.delete();
    end else if (v && am) begin
      m_frame[s] = d;
    end else if (v) begin
      if (PAR_EN && q_bits.size() == 32) begin
        w = pack_bits();
        m_perr = (^w) ^ d; m_frame = w; m_fv = 1'b1; q_bits.delete();
      end else begin
        q_bits.push_back(d);
        if (!PAR_EN && q_bits.size() == 32) begin
          m_frame = pack_bits(); m_fv = 1'b1; q_bits.delete();
        end
      end
    end
    #1;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Sends a full frame (plus parity bit when enabled); counts frame_valid pulses seen early.
  task automatic send_word(input logic [31:0] w, input logic pbit);
    fv_early = 0;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 5'd0, w[i], 1'b0, 1'b1);
      if (PAR_EN || i != 31) fv_early += int'(frame_valid);
    end
    if (PAR_EN) step(1'b1, 1'b0, 5'd0, pbit, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_checks += 5;
    if (frame_out !== 32'h0) begin n_fail++; $display("FAIL reset_frame: got %h want 0", frame_out); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    if (bit_ptr !== 5'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", bit_ptr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    idle();
  endtask

  task automatic test_frame();
    logic [31:0] w = 32'hA5A5_F00F;
    send_word(w, ^w);
    n_checks += 6;
    if (fv_early !== 0) begin n_fail++; $display("FAIL frame_early_fv: got %0d want 0", fv_early); end
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL frame_fv: got %b want 1", frame_valid); end
    if (frame_out !== w) begin n_fail++; $display("FAIL frame_word: got %h want %h", frame_out, w); end
    if (bit_ptr !== 5'd0) begin n_fail++; $display("FAIL frame_ptr: got %0d want 0", bit_ptr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy: got %b want 0", busy); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL frame_perr: got %b want 0", parity_err); end
    idle();
    n_checks += 2;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL frame_fv_1cyc: got %b want 0", frame_valid); end
    if (frame_out !== w) begin n_fail++; $display("FAIL frame_hold: got %h want %h", frame_out, w); end
  endtask

  task automatic test_back_to_back();
    int t1 = -1000, t2 = 0;
    send_word(32'h0000_0001, 1'b1);
    if (frame_valid) t1 = cyc;
    send_word(32'h8000_0000, 1'b1);
    if (frame_valid) t2 = cyc;
    n_checks += 3;
    if (t2 - t1 !== FRAME_LEN) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, FRAME_LEN);
    end
    if (frame_out !== 32'h8000_0000) begin
      n_fail++; $display("FAIL b2b_word: got %h want 80000000", frame_out);
    end
    if (fv_early !== 0) begin n_fail++; $display("FAIL b2b_early_fv: got %0d want 0", fv_early); end
    idle();
  endtask

  task automatic test_addressed();
    logic [31:0] w = $urandom;
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b1);
    n_checks += 1;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL addr_fv_a: got %b want 0", frame_valid); end
    step(1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
    n_checks += 4;
    if (frame_out !== 32'h8000_0001) begin
      n_fail++; $display("FAIL addr_word: got %h want 80000001", frame_out);
    end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL addr_fv_b: got %b want 0", frame_valid); end
    if (bit_ptr !== 5'd0) begin n_fail++; $display("FAIL addr_ptr: got %0d want 0", bit_ptr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL addr_busy: got %b want 0", busy); end
    // Partial auto frame must survive an interleaved addressed write.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 5'd0, w[i], 1'b0, 1'b1);
    step(1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    n_checks += 3;
    if (bit_ptr !== 5'd5) begin n_fail++; $display("FAIL addr_mid_ptr: got %0d want 5", bit_ptr); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL addr_mid_busy: got %b want 1", busy); end
    if (frame_out !== 32'h8000_0081) begin
      n_fail++; $display("FAIL addr_mid_word: got %h want 80000081", frame_out);
    end
    for (int i = 5; i < 32; i++) step(1'b1, 1'b0, 5'd0, w[i], 1'b0, 1'b1);
    if (PAR_EN) step(1'b1, 1'b0, 5'd0, ^w, 1'b0, 1'b1);
    n_checks += 2;
    if (frame_out !== w) begin n_fail++; $display("FAIL addr_resume_word: got %h want %h", frame_out, w); end
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL addr_resume_fv: got %b want 1", frame_valid); end
    idle();
  endtask

  task automatic test_clear();
    logic [31:0] held, w;
    held = frame_out;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 5'd0, 1'($urandom), 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    n_checks += 4;
    if (bit_ptr !== 5'd0) begin n_fail++; $display("FAIL clr_ptr: got %0d want 0", bit_ptr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b want 0", busy); end
    if (frame_out !== held) begin n_fail++; $display("FAIL clr_frame: got %h want %h", frame_out, held); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL clr_fv: got %b want 0", frame_valid); end
    // Clear with a valid bit at pointer 31 must not commit.
    for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    n_checks += 3;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL clr31_fv: got %b want 0", frame_valid); end
    if (frame_out !== held) begin n_fail++; $display("FAIL clr31_frame: got %h want %h", frame_out, held); end
    if (bit_ptr !== 5'd0) begin n_fail++; $display("FAIL clr31_ptr: got %0d want 0", bit_ptr); end
    w = 32'h0000_0300;
    send_word(w, ^w);
    n_checks += 1;
    if (frame_out !== w) begin n_fail++; $display("FAIL clr_residue: got %h want %h", frame_out, w); end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    n_checks += 5;
    if (frame_out !== 32'h0) begin n_fail++; $display("FAIL rmid_frame: got %h want 0", frame_out); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_fv: got %b want 0", frame_valid); end
    if (bit_ptr !== 5'd0) begin n_fail++; $display("FAIL rmid_ptr: got %0d want 0", bit_ptr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rmid_perr: got %b want 0", parity_err); end
    send_word(32'hFFFF_FFFF, 1'b0);
    n_checks += 1;
    if (frame_out !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL rmid_word: got %h want ffffffff", frame_out);
    end
    idle();
  endtask

  task automatic test_parity();
`ifdef DEMUX32_PARITY_CHK_EN
    send_word(32'h0000_0007, 1'b1);
    n_checks += 3;
    if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_ok_err: got %b want 0", parity_err); end
    if (frame_out !== 32'h7) begin n_fail++; $display("FAIL par_ok_word: got %h want 7", frame_out); end
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_fv: got %b want 1", frame_valid); end
    send_word(32'h0000_0007, 1'b0);
    n_checks += 3;
    if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_err: got %b want 1", parity_err); end
    if (frame_out !== 32'h7) begin n_fail++; $display("FAIL par_bad_word: got %h want 7", frame_out); end
    if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL par_bad_fv: got %b want 1", frame_valid); end
    idle();
    n_checks += 1;
    if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_hold: got %b want 1", parity_err); end
    // Clear while waiting for the parity bit discards the frame.
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    n_checks += 1;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL par_wait_busy: got %b want 1", busy); end
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL par_clr_busy: got %b want 0", busy); end
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL par_clr_fv: got %b want 0", frame_valid); end
    if (frame_out !== 32'h7) begin n_fail++; $display("FAIL par_clr_word: got %h want 7", frame_out); end
    idle();
`endif
  endtask

  task automatic test_random();
    int op;
    for (int n = 0; n < 800; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 2)       step(1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b0, 1'b0);
      else if (op < 6)  step(1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b1, 1'b1);
      else if (op < 22) step(1'b1, 1'b1, 5'($urandom), 1'($urandom), 1'b0, 1'b1);
      else if (op < 85) step(1'b1, 1'b0, 5'($urandom), 1'($urandom), 1'b0, 1'b1);
      else              step(1'b0, 1'($urandom), 5'($urandom), 1'($urandom), 1'b0, 1'b1);
      n_checks += 5;
      if (frame_out !== m_frame) begin
        n_fail++; $display("FAIL rnd_frame @%0d: got %h want %h", cyc, frame_out, m_frame);
      end
      if (frame_valid !== m_fv) begin
        n_fail++; $display("FAIL rnd_fv @%0d: got %b want %b", cyc, frame_valid, m_fv);
      end
      if (bit_ptr !== m_ptr()) begin
        n_fail++; $display("FAIL rnd_ptr @%0d: got %0d want %0d", cyc, bit_ptr, m_ptr());
      end
      if (busy !== (q_bits.size() != 0)) begin
        n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, busy, q_bits.size() != 0);
      end
      if (parity_err !== m_perr) begin
        n_fail++; $display("FAIL rnd_perr @%0d: got %b want %b", cyc, parity_err, m_perr);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_frame();
    test_back_to_back();
    test_addressed();
    test_clear();
    test_reset_mid();
    test_parity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
